// File: rtl/instr_fetch_unit.sv
// Instruction fetch: one outstanding imem request, then holds the returned word for decode.
// Request rises on the 2nd edge after reset; capture on ack; decode backpressure holds instr, next fetch follows accept.
module instr_fetch_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [15:0] PC_STEP  = 16'd2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_ack,
   input  logic [15:0] imem_rdata,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [15:0] instr,
   output logic [3:0]  opcode,
   output logic [15:0] instr_pc,
   input  logic        jump,
   input  logic        beq,
   input  logic        bne,
   input  logic        alu_zero
);

   typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

   state_t      state, state_nxt;
   logic        idle_done, idle_done_nxt;
   logic [15:0] pc, pc_nxt;
   logic [15:0] instr_nxt, instr_pc_nxt;
   logic        req_nxt, vld_nxt;
   logic        take_branch;
   logic [15:0] seq_pc, br_tgt, jump_tgt;

   assign imem_addr   = pc;
   assign opcode      = instr[15:12];
   assign seq_pc      = instr_pc + PC_STEP;
   assign br_tgt      = seq_pc + {{9{instr[5]}}, instr[5:0], 1'b0};
   assign jump_tgt    = {instr_pc[15:13], instr[11:0], 1'b0};
   assign take_branch = (beq && alu_zero) || (bne && !alu_zero);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         idle_done   <= 1'b0;
         pc          <= RESET_PC;
         imem_req    <= 1'b0;
         instr_valid <= 1'b0;
         instr       <= 16'h0000;
         instr_pc    <= 16'h0000;
      end else begin
         state       <= state_nxt;
         idle_done   <= idle_done_nxt;
         pc          <= pc_nxt;
         imem_req    <= req_nxt;
         instr_valid <= vld_nxt;
         instr       <= instr_nxt;
         instr_pc    <= instr_pc_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      idle_done_nxt = idle_done;
      pc_nxt        = pc;
      req_nxt       = imem_req;
      vld_nxt       = instr_valid;
      instr_nxt     = instr;
      instr_pc_nxt  = instr_pc;
      case (state)
         // first edge after reset only arms; the second launches the fetch
         IDLE: begin
            if (idle_done) begin
               state_nxt = FETCH;
               req_nxt   = 1'b1;
            end else begin
               idle_done_nxt = 1'b1;
            end
         end
         FETCH: begin
            if (imem_ack) begin
               instr_nxt    = imem_rdata;
               instr_pc_nxt = pc;
               req_nxt      = 1'b0;
               vld_nxt      = 1'b1;
               state_nxt    = HOLD;
            end
         end
         HOLD: begin
            if (instr_valid && instr_ready) begin
               if (jump)             pc_nxt = jump_tgt;
               else if (take_branch) pc_nxt = br_tgt;
               else                  pc_nxt = seq_pc;
               vld_nxt   = 1'b0;
               req_nxt   = 1'b1;
               state_nxt = FETCH;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: memory responder, decode handshake and reset cases.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [15:0] imem_rdata = 16'h0000;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [15:0] instr;
   logic [3:0]  opcode;
   logic [15:0] instr_pc;
   logic        jump = 1'b0, beq = 1'b0, bne = 1'b0, alu_zero = 1'b0;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   instr_fetch_unit #(.RESET_PC(16'h0000), .PC_STEP(16'd2)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .opcode(opcode), .instr_pc(instr_pc),
      .jump(jump), .beq(beq), .bne(bne), .alu_zero(alu_zero)
   );

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_req"}, {15'd0, imem_req}, 16'h0000);
      chk({tag, "_addr"}, imem_addr, 16'h0000);
      chk({tag, "_vld"}, {15'd0, instr_valid}, 16'h0000);
      chk({tag, "_instr"}, instr, 16'h0000);
      chk({tag, "_op"}, {12'd0, opcode}, 16'h0000);
      chk({tag, "_ipc"}, instr_pc, 16'h0000);
   endtask

   // wait (bounded) until imem_req is seen at a negedge, then check the address
   task automatic wait_req(input logic [15:0] exp_addr);
      int i;
      for (i = 0; i < 20; i++) begin
         if (imem_req) break;
         @(negedge clk);
      end
      chk("req_seen", {15'd0, imem_req}, 16'h0001);
      chk("req_addr", imem_addr, exp_addr);
   endtask

   // answer the pending request after lat cycles, then check the captured word
   task automatic do_fetch(input logic [15:0] exp_addr, input int lat, input logic [15:0] data);
      wait_req(exp_addr);
      for (int i = 1; i < lat; i++) begin
         @(negedge clk);
         chk("wait_req", {15'd0, imem_req}, 16'h0001);
         chk("wait_addr", imem_addr, exp_addr);
      end
      imem_ack   = 1'b1;
      imem_rdata = data;
      @(negedge clk);
      imem_ack   = 1'b0;
      chk("cap_vld", {15'd0, instr_valid}, 16'h0001);
      chk("cap_req", {15'd0, imem_req}, 16'h0000);
      chk("cap_instr", instr, data);
      chk("cap_ipc", instr_pc, exp_addr);
   endtask

   task automatic accept(input logic j, input logic bq, input logic bn, input logic z);
      instr_ready = 1'b1;
      jump = j; beq = bq; bne = bn; alu_zero = z;
      @(negedge clk);
      instr_ready = 1'b0;
      jump = 1'b0; beq = 1'b0; bne = 1'b0; alu_zero = 1'b0;
      chk("acc_vld", {15'd0, instr_valid}, 16'h0000);
      chk("acc_req", {15'd0, imem_req}, 16'h0001);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_reset_outputs("rst");

      // IDLE for one full cycle, request on the second edge
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_req", {15'd0, imem_req}, 16'h0000);
      @(negedge clk);
      chk("first_req", {15'd0, imem_req}, 16'h0001);

      // sequential fetch, then jump from 0x0004
      do_fetch(16'h0000, 1, 16'h1000); accept(0, 0, 0, 0);
      do_fetch(16'h0002, 1, 16'h2000); accept(0, 0, 0, 0);
      do_fetch(16'h0004, 1, 16'hD005); accept(1, 0, 0, 0);
      do_fetch(16'h000A, 1, 16'hD008); accept(1, 0, 0, 0);

      // beq with offset -2: taken then not taken
      do_fetch(16'h0010, 1, 16'h803E); accept(0, 1, 0, 1);
      do_fetch(16'h000E, 1, 16'hD008); accept(1, 0, 0, 0);
      do_fetch(16'h0010, 1, 16'h803E); accept(0, 1, 0, 0);

      // 4-cycle ack latency, undefined opcode, decode stall and spurious ack
      do_fetch(16'h0012, 4, 16'hF123);
      chk("op15", {12'd0, opcode}, 16'h000F);
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin imem_ack = 1'b1; imem_rdata = 16'hBEEF; end
         @(negedge clk);
         imem_ack = 1'b0;
         chk("stall_instr", instr, 16'hF123);
         chk("stall_ipc", instr_pc, 16'h0012);
         chk("stall_req", {15'd0, imem_req}, 16'h0000);
      end
      chk("stall_op", {12'd0, opcode}, 16'h000F);
      accept(0, 0, 0, 0);
      chk("resume_addr", imem_addr, 16'h0014);

      // bne taken with alu_zero=0, offset +2
      do_fetch(16'h0014, 1, 16'h9002); accept(0, 0, 1, 0);

      // reset mid-FETCH with a late ack straddling release
      wait_req(16'h001A);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("midrst");
      imem_ack = 1'b1; imem_rdata = 16'h5555;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      imem_ack = 1'b0;
      chk("late_vld", {15'd0, instr_valid}, 16'h0000);
      chk("late_instr", instr, 16'h0000);
      chk("late_req", {15'd0, imem_req}, 16'h0000);
      @(negedge clk);
      do_fetch(16'h0000, 1, 16'h3000); accept(0, 0, 0, 0);
      chk("post_rst_seq", imem_addr, 16'h0002);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, expected finish before 100000");
      $fatal(1);
   end

endmodule
